// File: rtl/nn_infer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_infer_sequencer
// Purpose  : Inference controller for the digit-recognition pipeline. It steps
//            through the stages, captures the digit and hands it to a
//            valid/ready consumer. Optional watchdog: `define SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nn_infer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [NUM_LAYERS-1:0] layer_en,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  layer_rst,
    input  logic [7:0]            digit_in,
    output logic [7:0]            digit_out,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic [15:0]           infer_cnt,
    output logic                  error
);

    localparam int c_STG_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int c_CLR_W = 4;

    if (NUM_LAYERS < 1 || CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("nn_infer_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [c_STG_W-1:0]    r_stage,     w_stage_nxt;
    logic [c_CLR_W-1:0]    r_clr_cnt,   w_clr_cnt_nxt;
    logic [NUM_LAYERS-1:0] r_layer_en,  w_layer_en_nxt;
    logic                  r_layer_rst, w_layer_rst_nxt;
    logic [7:0]            r_digit,     w_digit_nxt;
    logic                  r_valid,     w_valid_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic [15:0]           r_infer_cnt, w_infer_cnt_nxt;
    logic                  w_timeout;
    logic                  w_last_stage;

    assign w_last_stage = (r_stage == c_STG_W'(NUM_LAYERS - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_stage_nxt     = r_stage;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_digit_nxt     = r_digit;
        w_valid_nxt     = r_valid;
        w_infer_cnt_nxt = r_infer_cnt;
        w_layer_en_nxt  = '0;

        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == c_CLR_W'(CLEAR_CYCLES - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + c_CLR_W'(1);
                end
            end
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_stage_nxt = '0;
                end
            end
            S_RUN: begin
                // Only the active stage's flag matters; earlier flags stay high.
                if (layer_done[r_stage]) begin
                    if (w_last_stage) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_stage_nxt = r_stage + c_STG_W'(1);
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_CAPTURE: begin
                w_digit_nxt = digit_in;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (result_ready) begin
                    w_valid_nxt     = 1'b0;
                    w_infer_cnt_nxt = r_infer_cnt + 16'd1;
                    w_state_nxt     = S_CLEAR;
                    w_clr_cnt_nxt   = '0;
                end
            end
            S_ERROR: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase

        if (w_state_nxt == S_RUN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                w_layer_en_nxt[i] = (i <= int'(w_stage_nxt));
            end
        end else if (w_state_nxt == S_CAPTURE || w_state_nxt == S_RESULT) begin
            w_layer_en_nxt = '1;
        end

        w_layer_rst_nxt = (w_state_nxt == S_CLEAR);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_stage     <= '0;
            r_clr_cnt   <= '0;
            r_layer_en  <= '0;
            r_layer_rst <= 1'b1;
            r_digit     <= 8'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b1;
            r_infer_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage     <= w_stage_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_layer_en  <= w_layer_en_nxt;
            r_layer_rst <= w_layer_rst_nxt;
            r_digit     <= w_digit_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_infer_cnt <= w_infer_cnt_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_error;

    assign w_timeout = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // Restarts whenever a stage is (re)entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_RUN && w_state_nxt == S_RUN && w_stage_nxt == r_stage) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_state_nxt == S_ERROR) begin
            r_error <= 1'b1;
        end else if (r_state == S_IDLE && start) begin
            r_error <= 1'b0;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    assign layer_en     = r_layer_en;
    assign layer_rst    = r_layer_rst;
    assign digit_out    = r_digit;
    assign result_valid = r_valid;
    assign busy         = r_busy;
    assign infer_cnt    = r_infer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nn_infer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_infer_sequencer
// Purpose  : Self-checking bench for nn_infer_sequencer; expected timelines are
//            derived from stage latencies chosen by the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_infer_sequencer;

    localparam int c_NL  = 3;
    localparam int c_CLR = 2;
    localparam int c_TMO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [c_NL-1:0] layer_en;
    logic [c_NL-1:0] layer_done;
    logic            layer_rst;
    logic [7:0]      digit_in;
    logic [7:0]      digit_out;
    logic            result_valid;
    logic            result_ready;
    logic            busy;
    logic [15:0]     infer_cnt;
    logic            error;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [15:0] m_cnt  = 16'd0;
    logic        m_err  = 1'b0;

    nn_infer_sequencer #(
        .NUM_LAYERS    (c_NL),
        .CLEAR_CYCLES  (c_CLR),
        .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .layer_en    (layer_en),
        .layer_done  (layer_done),
        .layer_rst   (layer_rst),
        .digit_in    (digit_in),
        .digit_out   (digit_out),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .infer_cnt   (infer_cnt),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Runs one full inference from IDLE back to IDLE. lat[k] is the number of
    // cycles stage k spends in RUN; wait_cyc is the consumer back-pressure.
    task automatic run_one(input logic [7:0] dig, input int l0, input int l1, input int l2,
                           input int wait_cyc);
        int         lat[c_NL];
        logic [2:0] d;
        logic [2:0] exp_en;
        lat = '{l0, l1, l2};
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        m_err = 1'b0;
        chk("start_en", 32'(layer_en), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err", 32'(error), 32'(m_err));
        for (int k = 0; k < c_NL; k++) begin
            for (int c = 0; c < lat[k]; c++) begin
                d = 3'((1 << k) - 1);
                d = d | (3'($urandom) & ~3'((1 << (k + 1)) - 1));
                if (c == lat[k] - 1) d[k] = 1'b1;
                layer_done = d;
                digit_in   = (k == c_NL - 1 && c == lat[k] - 1) ? dig : 8'($urandom);
                step();
                exp_en = (c == lat[k] - 1) ? 3'((1 << (k + 2)) - 1) : 3'((1 << (k + 1)) - 1);
                chk("run_en", 32'(layer_en), 32'(exp_en));
                chk("run_valid", 32'(result_valid), 32'd0);
            end
        end
        digit_in = dig;
        step();
        chk("res_valid", 32'(result_valid), 32'd1);
        chk("res_digit", 32'(digit_out), 32'(dig));
        chk("res_en", 32'(layer_en), 32'd7);
        chk("res_cnt", 32'(infer_cnt), 32'(m_cnt));
        for (int w = 0; w < wait_cyc; w++) begin
            result_ready = 1'b0;
            start        = 1'($urandom);
            digit_in     = 8'($urandom);
            step();
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_digit", 32'(digit_out), 32'(dig));
            chk("hold_en", 32'(layer_en), 32'd7);
            chk("hold_cnt", 32'(infer_cnt), 32'(m_cnt));
        end
        result_ready = 1'b1;
        start        = 1'($urandom);
        step();
        result_ready = 1'b0;
        layer_done   = '0;
        m_cnt        = m_cnt + 16'd1;
        chk("acc_valid", 32'(result_valid), 32'd0);
        chk("acc_cnt", 32'(infer_cnt), 32'(m_cnt));
        chk("acc_rst", 32'(layer_rst), 32'd1);
        chk("acc_en", 32'(layer_en), 32'd0);
        for (int c = 1; c < c_CLR; c++) begin
            start = 1'($urandom);
            step();
            chk("clr_rst", 32'(layer_rst), 32'd1);
            chk("clr_busy", 32'(busy), 32'd1);
        end
        start = 1'($urandom);
        step();
        start = 1'b0;
        chk("idle_rst", 32'(layer_rst), 32'd0);
        chk("idle_busy2", 32'(busy), 32'd0);
        step();
        chk("noqueue_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(error), 32'(m_err));
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        layer_done   = '0;
        digit_in     = 8'd0;
        result_ready = 1'b0;
        step();
        step();
        chk("rst_layer_rst", 32'(layer_rst), 32'd1);
        chk("rst_en", 32'(layer_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_cnt", 32'(infer_cnt), 32'd0);
        chk("rst_err", 32'(error), 32'd0);

        reset = 1'b1;
        step();
        chk("rel_rst1", 32'(layer_rst), 32'd1);
        step();
        chk("rel_rst2", 32'(layer_rst), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_en", 32'(layer_en), 32'd0);

        run_one(8'd3, 3, 4, 2, 0);
        run_one(8'd3, 1, 1, 1, 10);
        for (int i = 0; i < 6; i++) begin
            run_one(8'($urandom_range(0, 9)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)));
        end

        // Abort in the middle of stage 1.
        start = 1'b1;
        step();
        start      = 1'b0;
        layer_done = 3'b001;
        step();
        chk("abort_pre_en", 32'(layer_en), 32'd3);
        layer_done = 3'b011;
        reset      = 1'b0;
        step();
        reset      = 1'b1;
        layer_done = '0;
        m_cnt      = 16'd0;
        chk("abort_en", 32'(layer_en), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_cnt", 32'(infer_cnt), 32'd0);
        chk("abort_rst", 32'(layer_rst), 32'd1);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("abort_noresult", 32'(result_valid), 32'd0);
        end
        run_one(8'd7, 2, 1, 3, 1);

`ifdef SEQ_TIMEOUT_EN
        start = 1'b1;
        step();
        start      = 1'b0;
        layer_done = 3'b001;
        step();
        chk("tmo_enter_en", 32'(layer_en), 32'd3);
        for (int c = 1; c < c_TMO; c++) begin
            step();
            chk("tmo_wait_en", 32'(layer_en), 32'd3);
            chk("tmo_wait_err", 32'(error), 32'd0);
        end
        step();
        m_err = 1'b1;
        chk("tmo_err", 32'(error), 32'd1);
        chk("tmo_en", 32'(layer_en), 32'd0);
        layer_done = '0;
        step();
        chk("tmo_clr_rst", 32'(layer_rst), 32'd1);
        chk("tmo_clr_err", 32'(error), 32'd1);
        for (int c = 1; c < c_CLR; c++) step();
        step();
        chk("tmo_idle_busy", 32'(busy), 32'd0);
        chk("tmo_idle_err", 32'(error), 32'd1);
        chk("tmo_cnt", 32'(infer_cnt), 32'(m_cnt));
        run_one(8'd5, 1, 2, 1, 0);
`endif

        // Counter wrap.
        force dut.r_infer_cnt = 16'hFFFF;
        step();
        release dut.r_infer_cnt;
        m_cnt = 16'hFFFF;
        step();
        chk("wrap_pre", 32'(infer_cnt), 32'hFFFF);
        run_one(8'd9, 1, 1, 2, 2);
        chk("wrap_cnt", 32'(infer_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
